// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake plus the memory strobe bus for mem_access_ctrl.
// slave  : the controller side (accepts requests, drives the memory).
// master : the control unit + memory side (issues requests, answers strobes).
interface mem_access_ctrl_if #(
    parameter int AW = 13,
    parameter int DW = 13
);
    // request channel
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic          req_instr;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    // response channel
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_err;
    // memory bus
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_dataIn;
    logic          mem_write;
    logic          mem_read;
    logic          mem_instr;
    logic [DW-1:0] mem_dataOut;
    logic          mem_done;

    modport slave (
        input  req_valid, req_write, req_instr, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_data, rsp_err,
        input  rsp_ready,
        output mem_address, mem_dataIn, mem_write, mem_read, mem_instr,
        input  mem_dataOut, mem_done
    );

    modport master (
        output req_valid, req_write, req_instr, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_data, rsp_err,
        output rsp_ready,
        input  mem_address, mem_dataIn, mem_write, mem_read, mem_instr,
        output mem_dataOut, mem_done
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time requester for the main memory.
// IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with out-of-range and timeout guards.
// Optional macro MEM_ACCESS_STATS_EN adds saturating stat_rd/stat_wr/stat_to.
module mem_access_ctrl #(
    parameter int AW      = 13,
    parameter int DW      = 13,
    parameter int DEPTH   = 13,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_ctrl_if.slave   bus
`ifdef MEM_ACCESS_STATS_EN
    ,
    output logic [15:0]        stat_rd,
    output logic [15:0]        stat_wr,
    output logic [7:0]         stat_to
`endif
);
    localparam int CW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          write;
        logic          instr;
    } req_t;

    state_t        state, nxt;
    req_t          req_q;
    logic [CW-1:0] cnt;
    logic [DW-1:0] rdata_q;
    logic [1:0]    err_q;
    logic          oor;
    logic          done_hit;
    logic          to_hit;

    assign oor = bus.req_addr >= AW'(DEPTH);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end

    // next state and all outputs; the memory bus is only live in ISSUE/WAIT
    always_comb begin
        nxt             = state;
        done_hit        = 1'b0;
        to_hit          = 1'b0;
        bus.req_ready   = 1'b0;
        bus.rsp_valid   = 1'b0;
        bus.rsp_data    = '0;
        bus.rsp_err     = 2'b00;
        bus.mem_address = '0;
        bus.mem_dataIn  = '0;
        bus.mem_write   = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_instr   = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) nxt = oor ? RESP : ISSUE;
            end
            ISSUE, WAIT: begin
                bus.mem_address = req_q.addr;
                bus.mem_dataIn  = req_q.wdata;
                bus.mem_instr   = req_q.instr;
                bus.mem_write   = req_q.write;
                bus.mem_read    = !req_q.write;
                if (state == ISSUE) begin
                    nxt = WAIT;
                end else if (bus.mem_done) begin
                    // done beats a simultaneous timeout
                    done_hit = 1'b1;
                    nxt      = RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    to_hit = 1'b1;
                    nxt    = RESP;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_data  = rdata_q;
                bus.rsp_err   = err_q;
                if (bus.rsp_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // request latch, wait counter and response payload
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            req_q   <= '0;
            cnt     <= '0;
            rdata_q <= '0;
            err_q   <= 2'b00;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    req_q.addr  <= bus.req_addr;
                    req_q.wdata <= bus.req_wdata;
                    req_q.write <= bus.req_write;
                    // a store never selects instruction memory
                    req_q.instr <= bus.req_instr & ~bus.req_write;
                    rdata_q     <= '0;
                    err_q       <= oor ? 2'b01 : 2'b00;
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    if (done_hit) begin
                        err_q <= 2'b00;
                        if (!req_q.write) rdata_q <= bus.mem_dataOut;
                    end else if (to_hit) begin
                        err_q   <= 2'b10;
                        rdata_q <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MEM_ACCESS_STATS_EN
    // saturating completion counters, bumped on the WAIT -> RESP transition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_rd <= '0;
            stat_wr <= '0;
            stat_to <= '0;
        end else begin
            if (done_hit && !req_q.write && stat_rd != '1) stat_rd <= stat_rd + 16'd1;
            if (done_hit &&  req_q.write && stat_wr != '1) stat_wr <= stat_wr + 16'd1;
            if (to_hit && stat_to != '1)                   stat_to <= stat_to + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl; the bench plays control unit and memory.
module tb_mem_access_ctrl;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    mem_access_ctrl_if #(.AW(13), .DW(13)) bus ();

`ifdef MEM_ACCESS_STATS_EN
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [7:0]  stat_to;
`endif

    mem_access_ctrl #(.AW(13), .DW(13), .DEPTH(13), .TIMEOUT(15)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
`ifdef MEM_ACCESS_STATS_EN
        ,
        .stat_rd (stat_rd),
        .stat_wr (stat_wr),
        .stat_to (stat_to)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic ins, input logic [12:0] a, input logic [12:0] d);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_instr = ins;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got %b exp 1", bus.req_ready); end
        checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
        checks++; if ({bus.rsp_data, bus.rsp_err} !== 15'h0) begin failures++; $display("FAIL rst_rsp got %h exp 0", {bus.rsp_data, bus.rsp_err}); end
        checks++; if ({bus.mem_address, bus.mem_dataIn, bus.mem_write, bus.mem_read, bus.mem_instr} !== 29'h0) begin
            failures++; $display("FAIL rst_mem got %h exp 0", {bus.mem_address, bus.mem_dataIn, bus.mem_write, bus.mem_read, bus.mem_instr}); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store();
        bus.mem_dataOut = 13'h1555;
        drive_req(1'b1, 1'b0, 13'd5, 13'h1ABC);
        tick();                                 // cycle 1: ISSUE
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0) begin failures++; $display("FAIL st_strobe got w=%b r=%b exp w=1 r=0", bus.mem_write, bus.mem_read); end
        checks++; if (bus.mem_address !== 13'd5) begin failures++; $display("FAIL st_addr got %h exp 5", bus.mem_address); end
        checks++; if (bus.mem_dataIn !== 13'h1ABC) begin failures++; $display("FAIL st_din got %h exp 1abc", bus.mem_dataIn); end
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL st_busy got %b exp 0", bus.req_ready); end
        tick();                                 // cycle 2: WAIT
        checks++; if (bus.mem_write !== 1'b1) begin failures++; $display("FAIL st_hold got %b exp 1", bus.mem_write); end
        tick();                                 // cycle 3: done two cycles after strobe
        bus.mem_done = 1'b1;
        tick();                                 // cycle 4: RESP
        bus.mem_done = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL st_rsp_valid got %b exp 1", bus.rsp_valid); end
        checks++; if (bus.rsp_err !== 2'b00 || bus.rsp_data !== 13'h0) begin failures++; $display("FAIL st_rsp got err=%b data=%h exp 00/0", bus.rsp_err, bus.rsp_data); end
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL st_drop got %b exp 0", bus.mem_write); end
        tick();                                 // rsp_ready=1 -> IDLE
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin failures++; $display("FAIL st_idle got v=%b r=%b exp 0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task automatic test_fetch();
        drive_req(1'b0, 1'b1, 13'd3, 13'h0);
        tick();                                 // cycle 1: ISSUE
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_instr !== 1'b1) begin
            failures++; $display("FAIL fe_strobe got r=%b w=%b i=%b exp 1/0/1", bus.mem_read, bus.mem_write, bus.mem_instr); end
        checks++; if (bus.mem_address !== 13'd3) begin failures++; $display("FAIL fe_addr got %h exp 3", bus.mem_address); end
        tick();                                 // cycle 2: WAIT, memory answers
        bus.mem_done    = 1'b1;
        bus.mem_dataOut = 13'h0F0F;
        tick();                                 // cycle 3: best-case RESP
        bus.mem_done    = 1'b0;
        bus.mem_dataOut = 13'h0;
        checks++; if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL fe_latency got %b exp 1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 13'h0F0F || bus.rsp_err !== 2'b00) begin failures++; $display("FAIL fe_rsp got %h/%b exp 0f0f/00", bus.rsp_data, bus.rsp_err); end
        tick();
    endtask

    task automatic test_out_of_range();
        drive_req(1'b0, 1'b0, 13'd13, 13'h0);
        tick();                                 // cycle 1: straight to RESP
        bus.req_valid = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 2'b01) begin failures++; $display("FAIL oor_rsp got v=%b err=%b exp 1/01", bus.rsp_valid, bus.rsp_err); end
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin failures++; $display("FAIL oor_strobe got r=%b w=%b exp 0/0", bus.mem_read, bus.mem_write); end
        checks++; if (bus.rsp_data !== 13'h0) begin failures++; $display("FAIL oor_data got %h exp 0", bus.rsp_data); end
        tick();
        checks++; if (bus.req_ready !== 1'b1 || bus.mem_read !== 1'b0) begin failures++; $display("FAIL oor_idle got rdy=%b r=%b exp 1/0", bus.req_ready, bus.mem_read); end
    endtask

    task automatic test_timeout();
        bus.mem_dataOut = 13'h1FFF;
        drive_req(1'b0, 1'b0, 13'd2, 13'h0);
        tick();                                 // cycle 1: ISSUE
        bus.req_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();                             // WAIT cycles 2..16
            checks++; if (bus.mem_read !== 1'b1 || bus.rsp_valid !== 1'b0) begin
                failures++; $display("FAIL to_wait%0d got r=%b v=%b exp 1/0", i, bus.mem_read, bus.rsp_valid); end
        end
        tick();                                 // cycle 17: RESP
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 2'b10) begin failures++; $display("FAIL to_rsp got v=%b err=%b exp 1/10", bus.rsp_valid, bus.rsp_err); end
        checks++; if (bus.rsp_data !== 13'h0 || bus.mem_read !== 1'b0) begin failures++; $display("FAIL to_data got %h r=%b exp 0/0", bus.rsp_data, bus.mem_read); end
        bus.mem_dataOut = 13'h0;
        tick();
    endtask

    task automatic test_back_to_back();
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 1'b0, 13'd4, 13'h0);
        tick();                                 // ISSUE
        drive_req(1'b1, 1'b1, 13'd12, 13'h0777); // next request waits in line
        tick();                                 // WAIT
        bus.mem_done    = 1'b1;
        bus.mem_dataOut = 13'h1234;
        tick();                                 // RESP, held
        bus.mem_dataOut = 13'h0BAD;             // done in RESP must be ignored
        for (int i = 0; i < 4; i++) begin
            checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 13'h1234 || bus.rsp_err !== 2'b00 || bus.req_ready !== 1'b0) begin
                failures++; $display("FAIL hold%0d got v=%b d=%h e=%b rdy=%b exp 1/1234/00/0", i, bus.rsp_valid, bus.rsp_data, bus.rsp_err, bus.req_ready); end
            tick();
        end
        bus.mem_done  = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();                                 // IDLE: pending request not taken yet
        checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_write !== 1'b0) begin
            failures++; $display("FAIL b2b_gap got v=%b rdy=%b w=%b exp 0/1/0", bus.rsp_valid, bus.req_ready, bus.mem_write); end
        tick();                                 // ISSUE of the store
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_write !== 1'b1 || bus.mem_instr !== 1'b0 || bus.mem_address !== 13'd12 || bus.mem_dataIn !== 13'h0777) begin
            failures++; $display("FAIL b2b_store got w=%b i=%b a=%h d=%h exp 1/0/c/777", bus.mem_write, bus.mem_instr, bus.mem_address, bus.mem_dataIn); end
        tick();                                 // WAIT
        bus.mem_done = 1'b1;
        tick();                                 // RESP
        bus.mem_done    = 1'b0;
        bus.mem_dataOut = 13'h0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 13'h0 || bus.rsp_err !== 2'b00) begin
            failures++; $display("FAIL b2b_rsp got v=%b d=%h e=%b exp 1/0/00", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        tick();
    endtask

`ifdef MEM_ACCESS_STATS_EN
    task automatic test_stats();
        checks++; if (stat_rd !== 16'd2 || stat_wr !== 16'd2 || stat_to !== 8'd1) begin
            failures++; $display("FAIL stats got rd=%0d wr=%0d to=%0d exp 2/2/1", stat_rd, stat_wr, stat_to); end
    endtask
`endif

    task automatic test_reset_in_wait();
        drive_req(1'b0, 1'b0, 13'd1, 13'h0);
        tick();                                 // ISSUE
        bus.req_valid = 1'b0;
        tick();                                 // WAIT
        tick();                                 // WAIT
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mem_read !== 1'b0 || bus.mem_address !== 13'h0 || bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            failures++; $display("FAIL rw_async got r=%b a=%h rdy=%b v=%b exp 0/0/1/0", bus.mem_read, bus.mem_address, bus.req_ready, bus.rsp_valid); end
        bus.mem_done    = 1'b1;
        bus.mem_dataOut = 13'h1111;
        tick();
        rst_n        = 1'b1;
        bus.mem_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.rsp_valid !== 1'b0 || bus.mem_read !== 1'b0) begin
                failures++; $display("FAIL rw_quiet%0d got v=%b r=%b exp 0/0", i, bus.rsp_valid, bus.mem_read); end
        end
`ifdef MEM_ACCESS_STATS_EN
        checks++; if (stat_rd !== 16'd0 || stat_wr !== 16'd0 || stat_to !== 8'd0) begin
            failures++; $display("FAIL stats_clr got rd=%0d wr=%0d to=%0d exp 0/0/0", stat_rd, stat_wr, stat_to); end
`endif
        drive_req(1'b0, 1'b0, 13'd7, 13'h0);
        tick();                                 // ISSUE
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_read !== 1'b1 || bus.mem_address !== 13'd7) begin failures++; $display("FAIL rw_next got r=%b a=%h exp 1/7", bus.mem_read, bus.mem_address); end
        tick();                                 // WAIT
        bus.mem_done    = 1'b1;
        bus.mem_dataOut = 13'h0AAA;
        tick();                                 // RESP
        bus.mem_done = 1'b0;
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 13'h0AAA || bus.rsp_err !== 2'b00) begin
            failures++; $display("FAIL rw_rsp got v=%b d=%h e=%b exp 1/0aaa/00", bus.rsp_valid, bus.rsp_data, bus.rsp_err); end
        tick();
`ifdef MEM_ACCESS_STATS_EN
        checks++; if (stat_rd !== 16'd1) begin failures++; $display("FAIL stats_rd got %0d exp 1", stat_rd); end
`endif
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_instr   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus.rsp_ready   = 1'b1;
        bus.mem_dataOut = '0;
        bus.mem_done    = 1'b0;
        test_reset();
        test_store();
        test_fetch();
        test_out_of_range();
        test_timeout();
        test_back_to_back();
`ifdef MEM_ACCESS_STATS_EN
        test_stats();
`endif
        test_reset_in_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
